varredura_polinomio: RTL and testbench

- Sequencer and result buffer placed around the polynomial evaluator `Resolve`.
- Sweeps x from x_ini to x_fim in steps of passo. For each point it drives the evaluator's inicio/x inputs and collects (x, result) on valid.
- Buffers the pairs in a small FIFO and presents them downstream with a valid/ready handshake.
- Coefficients a, b, c are wired directly to `Resolve` at top level and are not handled here.

---
 rtl/varredura_pkg.sv | 25 ++
 rtl/fila_resultados.sv | 62 ++++++
 rtl/varredura_polinomio.sv | 107 ++++++++++
 tb/tb_varredura_polinomio.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/varredura_pkg.sv
// Shared widths, FSM state codes and entry layout for the x-sweep sequencer
// around the polynomial evaluator.
package varredura_pkg;

    localparam int X_W     = 8;
    localparam int R_W     = 16;
    localparam int ENTRY_W = X_W + R_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PREP  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [R_W-1:0] r;
    } entrada_t;

    // A zero increment would never advance, so it behaves as a step of one.
    function automatic logic [X_W-1:0] passo_efetivo(input logic [X_W-1:0] p);
        return (p == '0) ? X_W'(1) : p;
    endfunction

endpackage

// File: rtl/fila_resultados.sv
// First-word fall-through FIFO holding {x, result} pairs; the head is visible
// on dout whenever the queue is non-empty.
module fila_resultados
    import varredura_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [ENTRY_W-1:0]        din,
    output logic [ENTRY_W-1:0]        dout,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == (PW+1)'(DEPTH));
    assign count = r_count;

    // A pop in the same cycle frees the slot, so a push against a full queue is
    // still legal then; otherwise the entry is dropped.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/varredura_polinomio.sv
// Sweeps x over [x_ini, x_fim] in steps of passo, feeding the evaluator one
// point at a time and queueing the (x, result) pairs for downstream.
module varredura_polinomio
    import varredura_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [X_W-1:0]   x_ini,
    input  logic [X_W-1:0]   x_fim,
    input  logic [X_W-1:0]   passo,
    output logic             busy,
    output logic             done,
    output logic             ev_inicio,
    output logic [X_W-1:0]   ev_x,
    input  logic             ev_ready,
    input  logic             ev_valid,
    input  logic [R_W-1:0]   ev_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   out_x,
    output logic [R_W-1:0]   out_data
);

    logic [2:0]             r_state;
    logic [2:0]             w_state_next;
    logic [X_W-1:0]         r_x;
    logic [X_W-1:0]         r_x_fim;
    logic [X_W-1:0]         r_step;
    logic                   r_done;

    logic [X_W:0]           w_soma;
    logic                   w_ultimo;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_drain_done;
    entrada_t               w_din;
    entrada_t               w_dout;

    // Nine-bit sum so a step past 255 ends the sweep instead of wrapping.
    assign w_soma   = {1'b0, r_x} + {1'b0, r_step};
    assign w_ultimo = (w_soma > {1'b0, r_x_fim});

    assign w_push       = (r_state == ST_WAIT) && ev_valid;
    assign w_pop        = out_valid && out_ready;
    assign w_drain_done = w_empty || ((w_count == ($clog2(DEPTH)+1)'(1)) && w_pop);
    assign w_din        = '{x: r_x, r: ev_result};

    fila_resultados #(.DEPTH(DEPTH)) u_fila (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (x_ini <= x_fim) ? ST_PREP : ST_DRAIN;
            ST_PREP:  if (ev_ready && !w_full) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (ev_valid) w_state_next = w_ultimo ? ST_DRAIN : ST_PREP;
            ST_DRAIN: if (w_drain_done) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_x_fim <= '0;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_DRAIN) && w_drain_done;
            if (r_state == ST_IDLE && start) begin
                r_x     <= x_ini;
                r_x_fim <= x_fim;
                r_step  <= passo_efetivo(passo);
            end else if (w_push && !w_ultimo) begin
                r_x <= w_soma[X_W-1:0];
            end
        end
    end

    // busy stays up through the done cycle so the pulse lies inside the busy window.
    assign busy      = (r_state != ST_IDLE) || r_done;
    assign done      = r_done;
    assign ev_inicio = (r_state == ST_ISSUE);
    assign ev_x      = r_x;
    assign out_valid = !w_empty;
    assign out_x     = w_dout.x;
    assign out_data  = w_dout.r;

endmodule

// File: tb/tb_varredura_polinomio.sv
// Bench for varredura_polinomio: a 5-cycle squaring evaluator model, a
// table of directed sweeps and hand-written backpressure/reset/empty cases.
module tb_varredura_polinomio;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  x_ini, x_fim, passo;
    logic        busy, done, ev_inicio;
    logic [7:0]  ev_x;
    logic        ev_ready, ev_valid;
    logic [15:0] ev_result;
    logic        out_valid, out_ready;
    logic [7:0]  out_x;
    logic [15:0] out_data;

    varredura_polinomio #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_ini     (x_ini),
        .x_fim     (x_fim),
        .passo     (passo),
        .busy      (busy),
        .done      (done),
        .ev_inicio (ev_inicio),
        .ev_x      (ev_x),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_result (ev_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Evaluator model: a=1, b=0, c=0, so result = x*x after five cycles.
    int         ev_cnt = 0;
    logic [7:0] lat_x = '0;
    int         first_valid_cyc;
    int         last_valid_cyc;
    initial begin
        ev_ready  = 1'b1;
        ev_valid  = 1'b0;
        ev_result = '0;
        forever begin
            @(negedge clk);
            if (ev_valid) begin
                ev_valid = 1'b0;
                ev_ready = 1'b1;
            end else if (ev_cnt > 0) begin
                ev_cnt--;
                if (ev_cnt == 0) begin
                    ev_valid  = 1'b1;
                    ev_result = {8'd0, lat_x} * {8'd0, lat_x};
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    last_valid_cyc = cyc;
                end
            end
            if (ev_inicio === 1'b1 && ev_ready) begin
                lat_x    = ev_x;
                ev_ready = 1'b0;
                ev_cnt   = 5;
            end
        end
    end

    int          n_issue, n_done, busy_cnt;
    int          start_cyc, first_issue_cyc, first_busy_cyc, first_ov_cyc;
    int          done_cyc, last_pop_cyc;
    logic [7:0]  got_x[$];
    logic [15:0] got_r[$];

    task automatic clear_stats();
        n_issue = 0; n_done = 0; busy_cnt = 0;
        start_cyc = -1; first_issue_cyc = -1; first_busy_cyc = -1; first_ov_cyc = -1;
        done_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1;
        got_x.delete();
        got_r.delete();
    endtask

    initial begin
        clear_stats();
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (start && !busy && start_cyc < 0) start_cyc = cyc;
                if (ev_inicio) begin
                    n_issue++;
                    if (first_issue_cyc < 0) first_issue_cyc = cyc;
                end
                if (busy) begin
                    busy_cnt++;
                    if (first_busy_cyc < 0) first_busy_cyc = cyc;
                end
                if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
                if (out_valid && out_ready) begin
                    got_x.push_back(out_x);
                    got_r.push_back(out_data);
                    last_pop_cyc = cyc;
                    $display("pop  x=%0d data=%0d @%0d", out_x, out_data, cyc);
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
        end
    end

    typedef struct {
        logic [7:0]       xi, xf, p;
        int               n;
        logic [7:0][7:0]  ex;
        logic [7:0][15:0] er;
    } vec_t;

    vec_t vecs[5];

    task automatic new_vec(input int i, input logic [7:0] xi, input logic [7:0] xf, input logic [7:0] p);
        vecs[i].xi = xi; vecs[i].xf = xf; vecs[i].p = p;
        vecs[i].n = 0; vecs[i].ex = '0; vecs[i].er = '0;
    endtask

    task automatic add_pt(input int i, input logic [7:0] x, input logic [15:0] r);
        vecs[i].ex[vecs[i].n] = x;
        vecs[i].er[vecs[i].n] = r;
        vecs[i].n++;
    endtask

    task automatic pulse_start(input logic [7:0] xi, input logic [7:0] xf, input logic [7:0] p);
        @(posedge clk); #1;
        x_ini = xi; x_fim = xf; passo = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 3000 && n_done == 0; k++) @(posedge clk);
        #1;
        check({name, " done_seen"}, 32'(n_done > 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("v%0d", i);
        clear_stats();
        pulse_start(vecs[i].xi, vecs[i].xf, vecs[i].p);
        wait_done(nm);
        $display("sweep %s x_ini=%0d x_fim=%0d passo=%0d issues=%0d pops=%0d",
                 nm, vecs[i].xi, vecs[i].xf, vecs[i].p, n_issue, got_x.size());
        check({nm, " issues"}, n_issue, vecs[i].n);
        check({nm, " entries"}, got_x.size(), vecs[i].n);
        for (int k = 0; k < vecs[i].n && k < got_x.size(); k++) begin
            check($sformatf("%s x[%0d]", nm, k), got_x[k], vecs[i].ex[k]);
            check($sformatf("%s r[%0d]", nm, k), got_r[k], vecs[i].er[k]);
        end
        check({nm, " done_pulses"}, n_done, 1);
        check({nm, " done_after_pop"}, done_cyc, last_pop_cyc + 1);
        check({nm, " issue_latency"}, first_issue_cyc, start_cyc + 2);
        check({nm, " out_latency"}, first_ov_cyc, first_valid_cyc + 1);
        check({nm, " busy_low"}, busy, 0);
        check({nm, " ev_x_hold"}, ev_x, vecs[i].ex[vecs[i].n-1]);
    endtask

    initial begin
        int bp_r[6];
        int rst_cyc;
        bp_r = '{0, 1, 4, 9, 16, 25};

        rst = 1'b1; start = 1'b0; x_ini = '0; x_fim = '0; passo = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ev_inicio", ev_inicio, 0);
        check("rst ev_x", ev_x, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_x", out_x, 0);
        check("rst out_data", out_data, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        new_vec(0, 8'd0, 8'd3, 8'd1);
        add_pt(0, 8'd0, 16'd0); add_pt(0, 8'd1, 16'd1); add_pt(0, 8'd2, 16'd4); add_pt(0, 8'd3, 16'd9);
        new_vec(1, 8'd250, 8'd255, 8'd4);
        add_pt(1, 8'd250, 16'd62500); add_pt(1, 8'd254, 16'd64516);
        new_vec(2, 8'd7, 8'd8, 8'd0);
        add_pt(2, 8'd7, 16'd49); add_pt(2, 8'd8, 16'd64);
        new_vec(3, 8'd10, 8'd30, 8'd10);
        add_pt(3, 8'd10, 16'd100); add_pt(3, 8'd20, 16'd400); add_pt(3, 8'd30, 16'd900);
        new_vec(4, 8'd200, 8'd200, 8'd5);
        add_pt(4, 8'd200, 16'd40000);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure: with the sink stalled only DEPTH points may be issued.
        clear_stats();
        out_ready = 1'b0;
        pulse_start(8'd0, 8'd5, 8'd1);
        repeat (200) @(posedge clk);
        #1;
        $display("stall issues=%0d out_valid=%0d busy=%0d", n_issue, out_valid, busy);
        check("bp stalled_issues", n_issue, DEPTH);
        check("bp out_valid", out_valid, 1);
        check("bp busy", busy, 1);
        check("bp head_x", out_x, 0);
        out_ready = 1'b1;
        wait_done("bp");
        check("bp issues", n_issue, 6);
        check("bp entries", got_x.size(), 6);
        for (int k = 0; k < 6 && k < got_x.size(); k++) begin
            check($sformatf("bp x[%0d]", k), got_x[k], k);
            check($sformatf("bp r[%0d]", k), got_r[k], bp_r[k]);
        end

        // Empty range: no evaluation, done two cycles after the start cycle.
        clear_stats();
        pulse_start(8'd9, 8'd3, 8'd1);
        repeat (10) @(posedge clk);
        #1;
        $display("empty issues=%0d done_cyc=%0d start_cyc=%0d busy_cnt=%0d", n_issue, done_cyc, start_cyc, busy_cnt);
        check("empty issues", n_issue, 0);
        check("empty done_pulses", n_done, 1);
        check("empty done_cyc", done_cyc, start_cyc + 2);
        check("empty busy_cycles", busy_cnt, 2);
        check("empty busy_first", first_busy_cyc, start_cyc + 1);

        // Reset while waiting on the evaluator; its late result must be ignored.
        clear_stats();
        pulse_start(8'd0, 8'd3, 8'd1);
        for (int k = 0; k < 100 && n_issue == 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rst_cyc = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("reset-in-wait valid_cyc=%0d rst_cyc=%0d out_valid=%0d busy=%0d", last_valid_cyc, rst_cyc, out_valid, busy);
        check("rw late_valid_seen", 32'(last_valid_cyc > rst_cyc), 1);
        check("rw out_valid", out_valid, 0);
        check("rw busy", busy, 0);
        check("rw entries", got_x.size(), 0);
        check("rw done", n_done, 0);
        check("rw ev_x", ev_x, 0);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
